// File: rtl/l2_assoc_cache.sv
// Set-associative write-back L2 cache with tree pseudo-LRU replacement.
// Hits complete in the requesting cycle; misses run WRITEBACK (if the victim is dirty) then FILL.
module l2_assoc_cache #(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [127:0] mem_wdata,
  input  logic [15:0]  mem_byte_enable,
  output logic [127:0] mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 12 - IDX;
  localparam int LW   = $clog2(WAYS);
  localparam int PW   = WAYS - 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t state_reg, state_next;

  logic [WAYS-1:0] valid_reg [SETS];
  logic [WAYS-1:0] dirty_reg [SETS];
  logic [PW-1:0]   plru_reg  [SETS];
  logic [LW-1:0]   victim_reg, victim_sel, hit_way;

  logic [IDX-1:0]  idx;
  logic [TAGW-1:0] tag;
  logic [WAYS-1:0] hit_vec, way_we;
  logic [WAYS-1:0][127:0]  way_line;
  logic [WAYS-1:0][TAGW-1:0] way_tag;
  logic [127:0] merged_line, line_in;
  logic hit, wr_hit, fill_we, latch_victim, hit_inc, miss_inc;
  logic unused_addr_bits;

  assign idx = mem_address[4 +: IDX];
  assign tag = mem_address[15 -: TAGW];
  assign unused_addr_bits = ^mem_address[3:0];

  // Tree bits live at heap positions 1..WAYS-1; a node bit names the subtree holding the victim.
  function automatic logic [LW-1:0] plru_victim(input logic [PW-1:0] bits);
    logic [2*WAYS-1:0] t;
    logic [LW:0]       node;
    t    = {{WAYS{1'b0}}, bits, 1'b0};
    node = (LW+1)'(1);
    for (int l = 0; l < LW; l++) node = {node[LW-1:0], t[node]};
    return node[LW-1:0];
  endfunction

  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] bits, input logic [LW-1:0] way);
    logic [2*WAYS-1:0] t;
    logic [LW:0]       node;
    logic              b;
    t    = {{WAYS{1'b0}}, bits, 1'b0};
    node = (LW+1)'(1);
    for (int l = 0; l < LW; l++) begin
      b       = way[LW-1-l];
      t[node] = ~b;
      node    = {node[LW-1:0], b};
    end
    return t[PW:1];
  endfunction

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      logic [127:0]    data_mem [SETS];
      logic [TAGW-1:0] tag_mem  [SETS];

      assign way_line[gi] = data_mem[idx];
      assign way_tag[gi]  = tag_mem[idx];
      assign hit_vec[gi]  = valid_reg[idx][gi] && (tag_mem[idx] == tag);
      assign way_we[gi]   = (wr_hit && (hit_way == LW'(gi))) || (fill_we && (victim_reg == LW'(gi)));

      always_ff @(posedge clk) begin
        if (way_we[gi]) begin
          data_mem[idx] <= line_in;
          tag_mem[idx]  <= tag;
        end
      end
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
      assign merged_line[8*gi +: 8] = mem_byte_enable[gi] ? mem_wdata[8*gi +: 8]
                                                          : way_line[hit_way][8*gi +: 8];
    end
  endgenerate

  assign hit       = |hit_vec;
  assign mem_rdata = way_line[hit_way];
  assign line_in   = fill_we ? pmem_rdata : merged_line;

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) if (hit_vec[w]) hit_way = LW'(w);
    // Descending scan so the lowest-numbered invalid way wins over the PLRU choice.
    victim_sel = plru_victim(plru_reg[idx]);
    for (int w = WAYS - 1; w >= 0; w--) if (!valid_reg[idx][w]) victim_sel = LW'(w);
  end

  always_comb begin
    state_next   = state_reg;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    latch_victim = 1'b0;
    wr_hit       = 1'b0;
    fill_we      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (hit) begin
            mem_resp = 1'b1;
            hit_inc  = 1'b1;
            wr_hit   = mem_write && !mem_read;
          end else begin
            miss_inc     = 1'b1;
            latch_victim = 1'b1;
            state_next   = dirty_reg[idx][victim_sel] ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {way_tag[victim_reg], idx, 4'b0};
        pmem_wdata   = way_line[victim_reg];
        if (pmem_resp) state_next = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {tag, idx, 4'b0};
        if (pmem_resp) begin
          fill_we    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      victim_reg <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        plru_reg[s]  <= '0;
      end
    end else begin
      state_reg <= state_next;
      if (latch_victim) victim_reg <= victim_sel;
      if (hit_inc) begin
        plru_reg[idx] <= plru_touch(plru_reg[idx], hit_way);
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end
      if (miss_inc && (miss_count != 16'hFFFF)) miss_count <= miss_count + 16'd1;
      if (wr_hit) dirty_reg[idx][hit_way] <= 1'b1;
      if (fill_we) begin
        valid_reg[idx][victim_reg] <= 1'b1;
        dirty_reg[idx][victim_reg] <= 1'b0;
      end
    end
  end

endmodule
